spi_mux_sel_ctrl: RTL and testbench

// - SPI master-side sequencer for the 8:1 MISO slave mux: arbitrates N requesters, drives the one-hot

---
 rtl/spi_mux_pkg.sv | 32 +++
 rtl/spi_mux_rr_arb.sv | 37 +++
 rtl/spi_mux_sel_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_spi_mux_sel_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mux_pkg.sv
// Shared types and helpers for the SPI MISO-mux sequencer.
// Contents:
//   N_SLAVES - number of requesters and the width of the select vector
//   SEL_W    - width of a slave index
//   state_t  - sequencer states
//   idx_to_onehot / onehot_to_idx - select vector <-> index conversion
package spi_mux_pkg;

   localparam int unsigned N_SLAVES = 8;
   localparam int unsigned SEL_W    = $clog2(N_SLAVES);

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   function automatic logic [N_SLAVES-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      idx_to_onehot = N_SLAVES'(1) << idx;
   endfunction

   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_SLAVES-1:0] oh);
      onehot_to_idx = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (oh[i]) onehot_to_idx = onehot_to_idx | SEL_W'(i);
      end
   endfunction

endpackage

// File: rtl/spi_mux_rr_arb.sv
// Request arbiter for the SPI MISO-mux sequencer (purely combinational).
// Macro SPI_MUX_RR_EN: defined -> round-robin search starting at ptr;
//                      undefined -> fixed priority, lowest index wins, no ptr port.
// Ports:
//   ptr      in  SEL_W     first index searched (round-robin build only)
//   req      in  N_SLAVES  level requests
//   gnt_oh_c out N_SLAVES  one-hot winner, all zero when nothing requests
module spi_mux_rr_arb
   import spi_mux_pkg::*;
(
`ifdef SPI_MUX_RR_EN
   input  logic [SEL_W-1:0]    ptr,
`endif
   input  logic [N_SLAVES-1:0] req,
   output logic [N_SLAVES-1:0] gnt_oh_c
);

   int unsigned idx;

   // Scan from the farthest candidate down to the nearest so the nearest requester wins.
   always_comb begin
      gnt_oh_c = '0;
      idx      = 0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
`ifdef SPI_MUX_RR_EN
         idx = (int'(ptr) + i) % N_SLAVES;
`else
         idx = i;
`endif
         if (req[idx]) begin
            gnt_oh_c      = '0;
            gnt_oh_c[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_mux_sel_ctrl.sv
// SPI master sequencer for an 8:1 MISO slave mux: arbitrates requesters, owns the one-hot
// mux select, generates mode-0 SCLK/MOSI and captures one DATA_W-bit word from MISO.
// Macro SPI_MUX_RR_EN selects round-robin arbitration (default: fixed priority).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          level request per slave, held until gnt
//   tx_data      per-slave transmit word, slice i for slave i, sampled at grant
//   gnt          one-hot 1-cycle pulse as transaction starts
//   oen_sel      one-hot slave select to the mux
//   miso         mux MISO output
//   sclk, mosi   SPI clock (idles low) and data out, MSB first
//   rx_data      captured word, rx_id its slave index, rx_valid 1-cycle strobe
//   busy         high while a transaction (ARB..GAP) is in progress
module spi_mux_sel_ctrl
   import spi_mux_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_GAP  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_SLAVES-1:0]        req,
   input  logic [N_SLAVES*DATA_W-1:0] tx_data,
   output logic [N_SLAVES-1:0]        gnt,
   output logic [N_SLAVES-1:0]        oen_sel,
   input  logic                       miso,
   output logic                       sclk,
   output logic                       mosi,
   output logic [DATA_W-1:0]          rx_data,
   output logic [SEL_W-1:0]           rx_id,
   output logic                       rx_valid,
   output logic                       busy
);

   localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam int unsigned HALF_W  = $clog2(2 * DATA_W);

   localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CS_GAP - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [HALF_W-1:0]   half, half_nxt;
   logic [DATA_W-1:0]   tx_sh, tx_sh_nxt;
   logic [DATA_W-1:0]   rx_sh, rx_sh_nxt;
   logic [SEL_W-1:0]    win, win_nxt;
   logic                sclk_nxt, mosi_nxt, rx_valid_nxt, busy_nxt;
   logic [N_SLAVES-1:0] gnt_nxt, oen_nxt;
   logic [DATA_W-1:0]   rx_data_nxt;
   logic [SEL_W-1:0]    rx_id_nxt;

   logic [N_SLAVES-1:0] win_oh_c;
   logic [SEL_W-1:0]    win_idx_c;
   logic                win_any_c;

`ifdef SPI_MUX_RR_EN
   logic [SEL_W-1:0]    ptr, ptr_nxt;
`endif

   spi_mux_rr_arb u_arb (
`ifdef SPI_MUX_RR_EN
      .ptr      (ptr),
`endif
      .req      (req),
      .gnt_oh_c (win_oh_c)
   );

   assign win_idx_c = onehot_to_idx(win_oh_c);
   assign win_any_c = |win_oh_c;

   // State and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         half     <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         win      <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         gnt      <= '0;
         oen_sel  <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         rx_id    <= '0;
         busy     <= 1'b0;
`ifdef SPI_MUX_RR_EN
         ptr      <= '0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         half     <= half_nxt;
         tx_sh    <= tx_sh_nxt;
         rx_sh    <= rx_sh_nxt;
         win      <= win_nxt;
         sclk     <= sclk_nxt;
         mosi     <= mosi_nxt;
         gnt      <= gnt_nxt;
         oen_sel  <= oen_nxt;
         rx_valid <= rx_valid_nxt;
         rx_data  <= rx_data_nxt;
         rx_id    <= rx_id_nxt;
         busy     <= busy_nxt;
`ifdef SPI_MUX_RR_EN
         ptr      <= ptr_nxt;
`endif
      end
   end

   // Next state and next register values.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      half_nxt     = half;
      tx_sh_nxt    = tx_sh;
      rx_sh_nxt    = rx_sh;
      win_nxt      = win;
      sclk_nxt     = sclk;
      mosi_nxt     = mosi;
      gnt_nxt      = '0;
      oen_nxt      = oen_sel;
      rx_valid_nxt = 1'b0;
      rx_data_nxt  = rx_data;
      rx_id_nxt    = rx_id;
`ifdef SPI_MUX_RR_EN
      ptr_nxt      = ptr;
`endif

      case (state)
         IDLE: begin
            if (|req) state_nxt = ARB;
         end
         ARB: begin
            // A request that vanished before this cycle leaves nothing to grant.
            if (win_any_c) begin
               state_nxt = SETUP;
               gnt_nxt   = win_oh_c;
               oen_nxt   = win_oh_c;
               win_nxt   = win_idx_c;
               tx_sh_nxt = tx_data[int'(win_idx_c) * DATA_W +: DATA_W];
               mosi_nxt  = tx_sh_nxt[DATA_W-1];
               cnt_nxt   = '0;
`ifdef SPI_MUX_RR_EN
               ptr_nxt   = SEL_W'((int'(win_idx_c) + 1) % N_SLAVES);
`endif
            end else begin
               state_nxt = IDLE;
            end
         end
         SETUP: begin
            // Last setup cycle launches the first rising edge and samples MISO with it.
            if (cnt == DIV_LAST) begin
               state_nxt = SHIFT;
               cnt_nxt   = '0;
               half_nxt  = '0;
               sclk_nxt  = 1'b1;
               rx_sh_nxt = {rx_sh[DATA_W-2:0], miso};
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         SHIFT: begin
            if (cnt == DIV_LAST) begin
               cnt_nxt = '0;
               if (sclk) begin
                  sclk_nxt  = 1'b0;
                  tx_sh_nxt = tx_sh << 1;
                  mosi_nxt  = tx_sh_nxt[DATA_W-1];
                  half_nxt  = half + HALF_W'(1);
               end else if (half == HALF_LAST) begin
                  state_nxt = HOLD;
               end else begin
                  sclk_nxt  = 1'b1;
                  rx_sh_nxt = {rx_sh[DATA_W-2:0], miso};
                  half_nxt  = half + HALF_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            // Deselect and publish the word on the same edge.
            if (cnt == DIV_LAST) begin
               state_nxt    = (CS_GAP == 0) ? IDLE : GAP;
               cnt_nxt      = '0;
               oen_nxt      = '0;
               rx_valid_nxt = 1'b1;
               rx_data_nxt  = rx_sh;
               rx_id_nxt    = win;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_spi_mux_sel_ctrl.sv
// Directed self-checking bench for spi_mux_sel_ctrl: models the mux plus 8 slaves
// (slave i returns 8'hA0+i) for a default instance and a CLK_DIV=1, CS_GAP=0 instance.
module tb_spi_mux_sel_ctrl;

   localparam int unsigned NS = 8;
   localparam int unsigned DW = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NS-1:0]     req, req2;
   logic [NS*DW-1:0]  tx_data, tx2;
   logic [NS-1:0]     gnt, oen_sel, gnt2, oen2;
   logic              miso, sclk, mosi, rx_valid, busy;
   logic              miso2, sclk2, mosi2, rx_valid2, busy2;
   logic [DW-1:0]     rx_data, rx_data2;
   logic [2:0]        rx_id, rx_id2;

   int n_cmp = 0;
   int n_bad = 0;
   int oh_err = 0;
   int bit_pos = DW - 1;
   int bit_pos2 = DW - 1;

   always #5 clk = ~clk;

   spi_mux_sel_ctrl #(.DATA_W(DW), .CLK_DIV(4), .CS_GAP(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .tx_data(tx_data), .gnt(gnt), .oen_sel(oen_sel),
      .miso(miso), .sclk(sclk), .mosi(mosi), .rx_data(rx_data), .rx_id(rx_id),
      .rx_valid(rx_valid), .busy(busy));

   spi_mux_sel_ctrl #(.DATA_W(DW), .CLK_DIV(1), .CS_GAP(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req2), .tx_data(tx2), .gnt(gnt2), .oen_sel(oen2),
      .miso(miso2), .sclk(sclk2), .mosi(mosi2), .rx_data(rx_data2), .rx_id(rx_id2),
      .rx_valid(rx_valid2), .busy(busy2));

   // Mux + slave model: selected slave shifts out A0+i MSB first, advancing on SCLK fall.
   function automatic logic slave_bit(input logic [NS-1:0] oh, input int pos);
      logic [7:0] d;
      int idx;
      idx = 0;
      for (int i = 0; i < NS; i++) if (oh[i]) idx = i;
      d = 8'hA0 + 8'(idx);
      if (oh == '0 || pos < 0) return 1'b0;
      return d[pos];
   endfunction

   wire sel_any  = |oen_sel;
   wire sel2_any = |oen2;
   assign miso  = slave_bit(oen_sel, bit_pos);
   assign miso2 = slave_bit(oen2, bit_pos2);

   always @(negedge sclk or negedge sel_any) begin
      if (!sel_any) bit_pos <= DW - 1;
      else          bit_pos <= bit_pos - 1;
   end

   always @(negedge sclk2 or negedge sel2_any) begin
      if (!sel2_any) bit_pos2 <= DW - 1;
      else           bit_pos2 <= bit_pos2 - 1;
   end

   always @(negedge clk) begin
      if ($countones(oen_sel) > 1) oh_err++;
      if ($countones(oen2) > 1)    oh_err++;
   end

   // Collect one transaction on dut; drops req once granted.
   task automatic observe(output logic [7:0] g, output logic [7:0] oen0, output int oen_n,
                          output logic [7:0] mb, output logic [7:0] rd, output logic [2:0] rid,
                          output int rv_n, output int gw, output bit to);
      int cyc;
      logic ps;
      g = '0; oen0 = '0; oen_n = 0; mb = '0; rd = '0; rid = '0; rv_n = 0; gw = 0; to = 1'b0;
      ps = 1'b0;
      cyc = 0;
      while (gnt == '0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      gw = cyc;
      if (gnt == '0) begin
         to = 1'b1;
         return;
      end
      g = gnt;
      oen0 = oen_sel;
      req = '0;
      cyc = 0;
      while (cyc < 400) begin
         if (oen_sel != '0) oen_n++;
         if (sclk && !ps) mb = {mb[6:0], mosi};
         ps = sclk;
         if (rx_valid) begin
            rv_n++;
            rd = rx_data;
            rid = rx_id;
         end else if (rv_n != 0) begin
            break;
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 400) to = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({gnt, oen_sel, sclk, mosi, rx_valid, busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got gnt=%h oen=%h sclk=%b mosi=%b rxv=%b busy=%b want all 0",
                  gnt, oen_sel, sclk, mosi, rx_valid, busy);
      end
      n_cmp++;
      if ({rx_data, rx_id} !== '0) begin
         n_bad++;
         $display("FAIL reset_rx: got rx_data=%h rx_id=%0d want 0/0", rx_data, rx_id);
      end
      n_cmp++;
      if ({oen2, busy2, sclk2} !== '0) begin
         n_bad++;
         $display("FAIL reset_dut2: got oen=%h busy=%b sclk=%b want 0", oen2, busy2, sclk2);
      end
   endtask

   task automatic test_single();
      logic [7:0] g, oen0, mb, rd;
      logic [2:0] rid;
      int oen_n, rv_n, gw;
      bit to;
      @(negedge clk);
      tx_data = '0;
      tx_data[2*DW +: DW] = 8'h3C;
      req = 8'h04;
      observe(g, oen0, oen_n, mb, rd, rid, rv_n, gw, to);
      n_cmp++;
      if (to !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got 1 want 0"); end
      n_cmp++;
      if (g !== 8'h04) begin n_bad++; $display("FAIL single_gnt: got %h want 04", g); end
      n_cmp++;
      if (oen0 !== 8'h04) begin n_bad++; $display("FAIL single_oen: got %h want 04", oen0); end
      n_cmp++;
      if (oen_n !== 72) begin n_bad++; $display("FAIL single_oen_len: got %0d want 72", oen_n); end
      n_cmp++;
      if (mb !== 8'h3C) begin n_bad++; $display("FAIL single_mosi: got %h want 3c", mb); end
      n_cmp++;
      if (rd !== 8'hA2 || rid !== 3'd2) begin
         n_bad++;
         $display("FAIL single_rx: got %h/%0d want a2/2", rd, rid);
      end
      n_cmp++;
      if (rv_n !== 1) begin n_bad++; $display("FAIL single_rxv_len: got %0d want 1", rv_n); end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (rx_data !== 8'hA2 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL single_hold: got rx_data=%h busy=%b want a2/0", rx_data, busy);
      end
   endtask

   task automatic test_dropped_req();
      bit seen;
      @(negedge clk);
      req = 8'h10;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_arb_busy: got %b want 1", busy); end
      req = '0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (gnt != '0 || oen_sel != '0) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL drop_no_gnt: got 1 want 0"); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid_shift();
      logic [7:0] g, oen0, mb, rd;
      logic [2:0] rid;
      int oen_n, rv_n, gw, cyc, rises;
      bit to;
      logic ps;
      @(negedge clk);
      tx_data = '0;
      tx_data[1*DW +: DW] = 8'hC3;
      req = 8'h02;
      cyc = 0;
      while (gnt == '0 && cyc < 60) begin @(negedge clk); cyc++; end
      req = '0;
      rises = 0;
      ps = 1'b0;
      while (rises < 4 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (sclk && !ps) rises++;
         ps = sclk;
      end
      n_cmp++;
      if (rises !== 4) begin n_bad++; $display("FAIL rst_mid_reach: got %0d rises want 4", rises); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({oen_sel, sclk, busy, rx_valid} !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: got oen=%h sclk=%b busy=%b rxv=%b want 0",
                  oen_sel, sclk, busy, rx_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_mid_no_rx: got rxv=%b rx_data=%h want 0/00", rx_valid, rx_data);
      end
      rst_n = 1'b1;
      req = 8'h02;
      observe(g, oen0, oen_n, mb, rd, rid, rv_n, gw, to);
      n_cmp++;
      if (to !== 1'b0 || g !== 8'h02 || oen_n !== 72) begin
         n_bad++;
         $display("FAIL rst_after_txn: got to=%b gnt=%h oen_len=%0d want 0/02/72", to, g, oen_n);
      end
      n_cmp++;
      if (rd !== 8'hA1 || rid !== 3'd1 || mb !== 8'hC3 || rv_n !== 1) begin
         n_bad++;
         $display("FAIL rst_after_rx: got rx=%h id=%0d mosi=%h rxv=%0d want a1/1/c3/1",
                  rd, rid, mb, rv_n);
      end
   endtask

`ifdef SPI_MUX_RR_EN
   task automatic test_round_robin();
      logic [7:0] g, oen0, mb, rd;
      logic [2:0] rid;
      int oen_n, rv_n, gw;
      bit to;
      apply_reset();
      for (int i = 0; i < NS; i++) tx_data[i*DW +: DW] = 8'h11 * 8'(i);
      for (int k = 0; k < 9; k++) begin
         req = 8'hFF;
         observe(g, oen0, oen_n, mb, rd, rid, rv_n, gw, to);
         n_cmp++;
         if (to !== 1'b0 || g !== 8'(1 << (k % NS))) begin
            n_bad++;
            $display("FAIL rr_gnt[%0d]: got %h want %h", k, g, 8'(1 << (k % NS)));
         end
         n_cmp++;
         if (rid !== 3'(k % NS) || rd !== 8'hA0 + 8'(k % NS)) begin
            n_bad++;
            $display("FAIL rr_rx[%0d]: got %h/%0d want %h/%0d", k, rd, rid,
                     8'hA0 + 8'(k % NS), k % NS);
         end
         if (k > 0) begin
            n_cmp++;
            if (gw + 1 < 3) begin
               n_bad++;
               $display("FAIL rr_gap[%0d]: got %0d idle-select cycles want >= 3", k, gw + 1);
            end
         end
      end
      req = '0;
      repeat (6) @(negedge clk);
   endtask
`else
   task automatic test_fixed_priority();
      logic [7:0] g, oen0, mb, rd;
      logic [2:0] rid;
      int oen_n, rv_n, gw;
      bit to;
      for (int k = 0; k < 3; k++) begin
         req = 8'h81;
         observe(g, oen0, oen_n, mb, rd, rid, rv_n, gw, to);
         n_cmp++;
         if (to !== 1'b0 || g !== 8'h01) begin
            n_bad++;
            $display("FAIL fp_gnt[%0d]: got %h want 01", k, g);
         end
         n_cmp++;
         if (rd !== 8'hA0 || rid !== 3'd0) begin
            n_bad++;
            $display("FAIL fp_rx[%0d]: got %h/%0d want a0/0", k, rd, rid);
         end
      end
      req = '0;
      repeat (6) @(negedge clk);
   endtask
`endif

   task automatic test_fast_div();
      logic [7:0] mb, rd;
      logic [2:0] rid;
      int oen_n, tog, rv_n, cyc;
      logic ps, pm;
      @(negedge clk);
      tx2 = '0;
      tx2[DW-1:0] = 8'h5A;
      req2 = 8'h01;
      cyc = 0;
      while (gnt2 == '0 && cyc < 60) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (gnt2 !== 8'h01) begin n_bad++; $display("FAIL fast_gnt: got %h want 01", gnt2); end
      req2 = '0;
      oen_n = 0; tog = 0; rv_n = 0; mb = '0; rd = '0; rid = '0;
      ps = 1'b0; pm = 1'b0;
      cyc = 0;
      while (cyc < 100) begin
         if (oen2 != '0) oen_n++;
         if (oen2 != '0 && sclk2 !== ps) tog++;
         if (sclk2 && !pm) mb = {mb[6:0], mosi2};
         ps = sclk2;
         pm = sclk2;
         if (rx_valid2) begin
            rv_n++;
            rd = rx_data2;
            rid = rx_id2;
         end else if (rv_n != 0) begin
            break;
         end
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (oen_n !== 18) begin n_bad++; $display("FAIL fast_oen_len: got %0d want 18", oen_n); end
      n_cmp++;
      if (tog !== 16) begin n_bad++; $display("FAIL fast_sclk_toggles: got %0d want 16", tog); end
      n_cmp++;
      if (rd !== 8'hA0 || rid !== 3'd0 || rv_n !== 1 || mb !== 8'h5A) begin
         n_bad++;
         $display("FAIL fast_rx: got rx=%h id=%0d rxv=%0d mosi=%h want a0/0/1/5a",
                  rd, rid, rv_n, mb);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0;
      req2 = '0;
      tx_data = '0;
      tx2 = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_single();
      test_dropped_req();
      test_reset_mid_shift();
`ifdef SPI_MUX_RR_EN
      test_round_robin();
`else
      test_fixed_priority();
`endif
      test_fast_div();
      n_cmp++;
      if (oh_err !== 0) begin
         n_bad++;
         $display("FAIL onehot_sel: got %0d multi-hot cycles want 0", oh_err);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
